conv_systolic_param: RTL and testbench
======================================

Name: conv_systolic_param

Overview:
- Parametrised successor to the fixed 4x4-image / 3x3-filter systolic convolution block.
- Computes a valid-mode 2-D convolution: an IMG_N x IMG_N unsigned image with a K x K unsigned filter, giving M x M outputs, where M = IMG_N-K+1.
- Adds three things the fixed block lacks: a start/busy/done control handshake, a streamed output with valid/ready backpressure, and a selectable saturate or wrap output mode.
- Sits between the input/filter staging registers and the downstream result buffer.

Parameters:
- DATA_W, 8: width of each image and filter element (unsigned).
- ACC_W, 20: accumulator width; must be >= 2*DATA_W+clog2(K*K).
- OUT_W, 8: width of each output element.
- IMG_N, 4: image side length; must be >= K.
- K, 3: filter side length; must be >= 1.

Ports:
- clk_in  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a convolution; sampled only in IDLE.
- sat_en  input  1  1 = saturate outputs, 0 = truncate to the low OUT_W bits; captured on start.
- img_in  input  IMG_N*IMG_N*DATA_W  packed image, element (r,c) at index r*IMG_N+c, element 0 in the LSBs; captured on start.
- flt_in  input  K*K*DATA_W  packed filter, element (r,c) at index r*K+c; captured on start.
- busy  output  1  high from the accepted start until the job completes.
- done  output  1  one-cycle pulse after the last output is accepted.
- out_valid  output  1  out_data, out_row and out_col hold a result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  OUT_W  convolution result.
- out_row  output  max(1,clog2(M))  output row index.
- out_col  output  max(1,clog2(M))  output column index.

Behaviour:
- Reset:
  - rst low clears immediately, regardless of clock: state=IDLE, busy=0, done=0, out_valid=0, out_data=0, out_row=0, out_col=0, accumulator=0, counters=0, captured image/filter/sat_en=0.
  - Reset asserted mid-job aborts the job; no partial outputs are emitted after release.
- FSM states: IDLE, COMPUTE, EMIT.
- IDLE:
  - On an edge with start=1: capture img_in, flt_in and sat_en; clear the accumulator; set position (row,col)=(0,0) and filter-row counter kr=0; go to COMPUTE; busy=1.
  - start=0 keeps the block in IDLE.
- COMPUTE:
  - Each edge adds sum over c=0..K-1 of img[row+kr][col+c]*flt[kr][c] to the accumulator (K parallel multipliers plus an adder tree), then increments kr.
  - After the edge with kr=K-1, go to EMIT.
  - The accumulator wraps modulo 2^ACC_W; it cannot overflow within the legal ACC_W bound.
- EMIT:
  - out_valid=1, out_row=row, out_col=col.
  - out_data = (sat_en_captured && acc > 2^OUT_W-1) ? 2^OUT_W-1 : acc[OUT_W-1:0].
  - All output values stay stable while out_ready=0, for any number of cycles.
  - Handshake edge (out_valid and out_ready both 1):
    - Not the last position: advance to the next position in row-major order (col wraps to 0 at M and row increments), clear acc and kr, go to COMPUTE, out_valid=0.
    - Last position (M-1,M-1): go to IDLE, busy=0, out_valid=0, done=1 for exactly one cycle.
- Timing:
  - Latency from the start edge E0 to the first out_valid is K edges; with out_ready=1, each output takes K+1 edges.
  - The final handshake is at E0+M*M*(K+1); done is high during the following cycle.
- start while busy is ignored and never corrupts captured data. start on the same edge done falls is accepted normally (a back-to-back job).
- Changes on img_in, flt_in or sat_en after the capture edge do not affect the running job.
- K=IMG_N gives M=1: a single output, then done.

Test Plan:
- Basic convolution: defaults; img(r,c)=4r+c; filter all 1; sat_en=0; out_ready=1 -> outputs (0,0)=45, (0,1)=54, (1,0)=81, (1,1)=90 in that order; first out_valid after edge E0+3; done pulse after edge E0+16.
- Saturation vs wrap: image and filter all 255 (acc=585225) -> sat_en=1 gives every out_data=255; sat_en=0 gives every out_data=9.
- Backpressure: basic convolution stimulus with out_ready held 0 for 5 cycles on the first result -> out_valid stays 1, out_data=45 and (0,0) remain stable; the sequence and values are otherwise unchanged and done is delayed by 5 cycles.
- Start while busy: pulse start with a different image mid-job -> the original results 45/54/81/90 are still produced, with exactly one done pulse.
- Mid-job reset: rst low during the second COMPUTE -> busy, out_valid and out_data all 0 at once; after release a new start gives the correct full sequence.
- Parametrisation: IMG_N=5, K=2, ones image, ones filter -> 16 outputs, each equal to 4, (row,col) row-major from (0,0) to (3,3), and done after edge E0+48.

Source files
------------

// File: rtl/conv_systolic_param.sv
// Parametrised valid-mode 2-D convolution engine.
// One filter row (K parallel multipliers plus an adder tree) is accumulated per
// clock. Each finished output is held on a valid/ready stream until accepted.
// An optional saturation stage clamps the result to OUT_W bits.
module conv_systolic_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 20,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned IMG_N  = 4,
  parameter int unsigned K      = 3,
  localparam int unsigned M     = IMG_N - K + 1,
  localparam int unsigned RW    = (M > 1) ? $clog2(M) : 1
) (
  input  logic                          clk_in,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          sat_en,
  input  logic [IMG_N*IMG_N*DATA_W-1:0] img_in,
  input  logic [K*K*DATA_W-1:0]         flt_in,
  output logic                          busy,
  output logic                          done,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              out_data,
  output logic [RW-1:0]                 out_row,
  output logic [RW-1:0]                 out_col
);

  localparam int unsigned KW  = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned IBW = (IMG_N*IMG_N*DATA_W > 1) ? $clog2(IMG_N*IMG_N*DATA_W) : 1;
  localparam int unsigned FBW = (K*K*DATA_W > 1) ? $clog2(K*K*DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, EMIT} state_t;

  state_t                        state_q, state_d;
  logic [IMG_N*IMG_N*DATA_W-1:0] img_q, img_d;
  logic [K*K*DATA_W-1:0]         flt_q, flt_d;
  logic                          sat_q, sat_d;
  logic [ACC_W-1:0]              acc_q, acc_d;
  logic [RW-1:0]                 row_q, row_d;
  logic [RW-1:0]                 col_q, col_d;
  logic [KW-1:0]                 kr_q, kr_d;
  logic                          done_q, done_d;

  logic [DATA_W-1:0]   pix, wgt;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    row_sum;
  logic                kr_last, last_pos, sat_hit;

  assign kr_last  = (kr_q == KW'(K - 1));
  assign last_pos = (row_q == RW'(M - 1)) && (col_q == RW'(M - 1));

  // Dot product of image row (row+kr) window with filter row kr
  always_comb begin
    pix     = '0;
    wgt     = '0;
    prod    = '0;
    row_sum = '0;
    for (int unsigned c = 0; c < K; c++) begin
      pix = img_q[IBW'(((32'(row_q) + 32'(kr_q)) * IMG_N + 32'(col_q) + c) * DATA_W) +: DATA_W];
      wgt = flt_q[FBW'((32'(kr_q) * K + c) * DATA_W) +: DATA_W];
      prod = {{DATA_W{1'b0}}, pix} * {{DATA_W{1'b0}}, wgt};
      row_sum = row_sum + ACC_W'(prod);
    end
  end

  // Next-state logic for the IDLE/COMPUTE/EMIT controller and datapath
  always_comb begin
    state_d = state_q;
    img_d   = img_q;
    flt_d   = flt_q;
    sat_d   = sat_q;
    acc_d   = acc_q;
    row_d   = row_q;
    col_d   = col_q;
    kr_d    = kr_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          img_d   = img_in;
          flt_d   = flt_in;
          sat_d   = sat_en;
          acc_d   = '0;
          row_d   = '0;
          col_d   = '0;
          kr_d    = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        acc_d = acc_q + row_sum;
        if (kr_last) begin
          kr_d    = '0;
          state_d = EMIT;
        end else begin
          kr_d = kr_q + KW'(1);
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_pos) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            if (col_q == RW'(M - 1)) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + RW'(1);
            end
            acc_d   = '0;
            kr_d    = '0;
            state_d = COMPUTE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      img_q   <= '0;
      flt_q   <= '0;
      sat_q   <= 1'b0;
      acc_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      kr_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      img_q   <= img_d;
      flt_q   <= flt_d;
      sat_q   <= sat_d;
      acc_q   <= acc_d;
      row_q   <= row_d;
      col_q   <= col_d;
      kr_q    <= kr_d;
      done_q  <= done_d;
    end
  end

  assign sat_hit   = (acc_q >> OUT_W) != '0;
  assign out_data  = (sat_q && sat_hit) ? '1 : acc_q[OUT_W-1:0];
  assign out_valid = (state_q == EMIT);
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_conv_systolic_param.sv
// Bench for conv_systolic_param: default 4x4/3x3 instance plus a 5x5/2x2 instance.
module tb_conv_systolic_param;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst;

  // Instance A: IMG_N=4, K=3, M=2
  logic         start_a, sat_a, ready_a;
  logic [127:0] img_a;
  logic [71:0]  flt_a;
  logic         busy_a, done_a, valid_a;
  logic [7:0]   data_a;
  logic [0:0]   row_a, col_a;

  // Instance B: IMG_N=5, K=2, M=4
  logic         start_b, sat_b, ready_b;
  logic [199:0] img_b;
  logic [31:0]  flt_b;
  logic         busy_b, done_b, valid_b;
  logic [7:0]   data_b;
  logic [1:0]   row_b, col_b;

  conv_systolic_param #(.DATA_W(8), .ACC_W(20), .OUT_W(8), .IMG_N(4), .K(3)) dut_a (
    .clk_in(clk_in), .rst(rst), .start(start_a), .sat_en(sat_a),
    .img_in(img_a), .flt_in(flt_a), .busy(busy_a), .done(done_a),
    .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a),
    .out_row(row_a), .out_col(col_a));

  conv_systolic_param #(.DATA_W(8), .ACC_W(20), .OUT_W(8), .IMG_N(5), .K(2)) dut_b (
    .clk_in(clk_in), .rst(rst), .start(start_b), .sat_en(sat_b),
    .img_in(img_b), .flt_in(flt_b), .busy(busy_b), .done(done_b),
    .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b),
    .out_row(row_b), .out_col(col_b));

  int unsigned compared = 0;
  int unsigned mismatched = 0;
  int unsigned cyc = 0;
  int unsigned done_seen_a = 0, done_seen_b = 0;
  int unsigned exp_done_a = 0, exp_done_b = 0;

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (done_a === 1'b1) done_seen_a++;
    if (done_b === 1'b1) done_seen_b++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: direct valid-mode convolution over flat arrays
  function automatic logic [63:0] ref_conv(input int unsigned im[$], input int unsigned fl[$],
                                           input int n, input int k, input int r, input int c,
                                           input bit sat);
    longint unsigned s = 0;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        s += longint'(im[(r + i) * n + c + j]) * longint'(fl[i * k + j]);
    s = s % (64'd1 << 20);
    if (sat && s > 255) return 64'd255;
    return s % 256;
  endfunction

  task automatic job_a(input int unsigned im[$], input int unsigned fl[$], input bit sat,
                       input int stall, input bit mid_start);
    int unsigned e0;
    int n;
    logic [63:0] exp;
    logic [7:0] d0;
    for (int i = 0; i < 16; i++) img_a[i*8 +: 8] = 8'(im[i]);
    for (int i = 0; i < 9; i++) flt_a[i*8 +: 8] = 8'(fl[i]);
    sat_a = sat;
    start_a = 1'b1;
    ready_a = (stall == 0);
    @(posedge clk_in); #1;
    e0 = cyc;
    start_a = 1'b0;
    check("a_done_count", 64'(done_seen_a), 64'(exp_done_a));
    check("a_busy_start", 64'(busy_a), 1);
    // inputs scrambled after capture must not matter
    img_a = {4{$urandom}};
    flt_a = 72'({3{$urandom}});
    sat_a = ~sat;
    for (int p = 0; p < 4; p++) begin
      n = 0;
      while (valid_a !== 1'b1 && n < 40) begin @(posedge clk_in); #1; n++; end
      check("a_valid", 64'(valid_a), 1);
      if (p == 0) check("a_first_latency", 64'(cyc - e0), 3);
      exp = ref_conv(im, fl, 4, 3, p / 2, p % 2, sat);
      check("a_data", 64'(data_a), exp);
      check("a_row", 64'(row_a), 64'(p / 2));
      check("a_col", 64'(col_a), 64'(p % 2));
      if (p == 0 && stall > 0) begin
        d0 = data_a;
        repeat (stall) begin
          @(posedge clk_in); #1;
          check("a_stall_valid", 64'(valid_a), 1);
          check("a_stall_data", 64'(data_a), 64'(d0));
          check("a_stall_pos", 64'({row_a, col_a}), 0);
        end
        ready_a = 1'b1;
      end
      if (p == 1 && mid_start) begin
        start_a = 1'b1;
        img_a = {4{$urandom}};
      end
      @(posedge clk_in); #1;
      start_a = 1'b0;
      if (p < 3) check("a_valid_drop", 64'(valid_a), 0);
    end
    check("a_done", 64'(done_a), 1);
    check("a_busy_end", 64'(busy_a), 0);
    check("a_valid_end", 64'(valid_a), 0);
    check("a_total_latency", 64'(cyc - e0), 64'(16 + stall));
    exp_done_a++;
  endtask

  task automatic job_b(input int unsigned im[$], input int unsigned fl[$], input bit sat);
    int unsigned e0;
    int n;
    for (int i = 0; i < 25; i++) img_b[i*8 +: 8] = 8'(im[i]);
    for (int i = 0; i < 4; i++) flt_b[i*8 +: 8] = 8'(fl[i]);
    sat_b = sat;
    start_b = 1'b1;
    ready_b = 1'b1;
    @(posedge clk_in); #1;
    e0 = cyc;
    start_b = 1'b0;
    check("b_done_count", 64'(done_seen_b), 64'(exp_done_b));
    for (int p = 0; p < 16; p++) begin
      n = 0;
      while (valid_b !== 1'b1 && n < 40) begin @(posedge clk_in); #1; n++; end
      check("b_valid", 64'(valid_b), 1);
      if (p == 0) check("b_first_latency", 64'(cyc - e0), 2);
      check("b_data", 64'(data_b), ref_conv(im, fl, 5, 2, p / 4, p % 4, sat));
      check("b_row", 64'(row_b), 64'(p / 4));
      check("b_col", 64'(col_b), 64'(p % 4));
      @(posedge clk_in); #1;
    end
    check("b_done", 64'(done_b), 1);
    check("b_busy_end", 64'(busy_b), 0);
    check("b_total_latency", 64'(cyc - e0), 48);
    exp_done_b++;
  endtask

  initial begin
    int unsigned basic[$], ones9[$], full[$], f255[$], im[$], fl[$], ones25[$], ones4[$];
    int n;
    for (int i = 0; i < 16; i++) begin basic.push_back(i); full.push_back(255); end
    for (int i = 0; i < 9; i++) begin ones9.push_back(1); f255.push_back(255); end
    for (int i = 0; i < 25; i++) ones25.push_back(1);
    for (int i = 0; i < 4; i++) ones4.push_back(1);

    rst = 1'b0;
    start_a = 1'b0; sat_a = 1'b0; ready_a = 1'b1; img_a = '0; flt_a = '0;
    start_b = 1'b0; sat_b = 1'b0; ready_b = 1'b1; img_b = '0; flt_b = '0;
    #12;
    check("rst_busy", 64'(busy_a), 0);
    check("rst_done", 64'(done_a), 0);
    check("rst_valid", 64'(valid_a), 0);
    check("rst_data", 64'(data_a), 0);
    check("rst_pos", 64'({row_a, col_a}), 0);
    check("rst_b_busy", 64'(busy_b), 0);
    @(posedge clk_in); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check("idle_no_start", 64'(busy_a), 0);

    // basic, then back-to-back saturate and wrap jobs
    job_a(basic, ones9, 1'b0, 0, 1'b0);
    job_a(full, f255, 1'b1, 0, 1'b0);
    job_a(full, f255, 1'b0, 0, 1'b0);
    repeat (2) @(posedge clk_in);
    #1;
    // backpressure and start-while-busy
    job_a(basic, ones9, 1'b0, 5, 1'b0);
    job_a(basic, ones9, 1'b0, 0, 1'b1);

    // mid-job reset during the second COMPUTE phase
    img_a = '0;
    for (int i = 0; i < 16; i++) img_a[i*8 +: 8] = 8'(i);
    flt_a = {9{8'd1}};
    start_a = 1'b1;
    @(posedge clk_in); #1;
    start_a = 1'b0;
    check("r_done_count", 64'(done_seen_a), 64'(exp_done_a));
    n = 0;
    while (valid_a !== 1'b1 && n < 40) begin @(posedge clk_in); #1; n++; end
    check("r_valid", 64'(valid_a), 1);
    @(posedge clk_in); #1;
    @(posedge clk_in); #2;
    check("r_data_before", 64'(data_a != 8'd0), 1);
    rst = 1'b0;
    #1;
    check("r_busy", 64'(busy_a), 0);
    check("r_valid0", 64'(valid_a), 0);
    check("r_data0", 64'(data_a), 0);
    @(posedge clk_in); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check("r_still_idle", 64'({busy_a, valid_a}), 0);
    job_a(basic, ones9, 1'b0, 0, 1'b0);

    // randomized jobs
    for (int t = 0; t < 6; t++) begin
      im = {}; fl = {};
      for (int i = 0; i < 16; i++) im.push_back($urandom_range(255));
      for (int i = 0; i < 9; i++) fl.push_back($urandom_range(255));
      job_a(im, fl, 1'($urandom_range(1)), int'($urandom_range(3)), 1'b0);
    end

    // parametrised instance
    job_b(ones25, ones4, 1'b0);
    im = {}; fl = {};
    for (int i = 0; i < 25; i++) im.push_back($urandom_range(255));
    for (int i = 0; i < 4; i++) fl.push_back($urandom_range(255));
    job_b(im, fl, 1'($urandom_range(1)));

    @(posedge clk_in); #1;
    check("a_final_done_count", 64'(done_seen_a), 64'(exp_done_a));
    check("b_final_done_count", 64'(done_seen_b), 64'(exp_done_b));
    check("a_final_done_low", 64'(done_a), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
